// File: rtl/seq_mult_if.sv
// Operand/result bundle between a requester and seq_mult.
// master drives go/left/right; slave (the multiplier) drives ready/done/out.
interface seq_mult_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (output go, left, right, input ready, done, out);
  modport slave  (input go, left, right, output ready, done, out);
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: low WIDTH bits of left*right, one bit per cycle.
// Optional macro SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  seq_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_n, out_q;
  logic [CW-1:0]    count;
  logic             last;

  always_comb begin
    acc_n = acc + (mplier[0] ? mcand : '0);
    last  = (count == CW'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is empty.
    last  = last || ((mplier >> 1) == '0);
`endif
    state_n = state;
    case (state)
      IDLE, DONE: state_n = bus.go ? BUSY : IDLE;
      BUSY:       if (last) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      out_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: begin
          if (bus.go) begin
            mcand  <= bus.left;
            mplier <= bus.right;
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // out only moves on the BUSY->DONE transition, so it holds between products.
          if (last) out_q <= acc_n;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state != BUSY);
  assign bus.done  = (state == DONE);
  assign bus.out   = out_q;
endmodule

// File: tb/tb_seq_mult.sv
// Directed-vector bench for seq_mult at WIDTH=8 (fixed and early-exit builds).
module tb_seq_mult;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  seq_mult_if #(.WIDTH(W)) bus ();
  seq_mult #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge: one cycle later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from go to done for a given multiplier.
  function automatic int exp_lat(input logic [W-1:0] r);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < W; i++) if (r[i]) m = i + 1;
    return ((m < 1) ? 1 : m) + 1;
`else
    return W + 1;
`endif
  endfunction

  // Issue go in the current cycle, scramble inputs while BUSY, check done timing and result.
  task automatic run_op(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [W-1:0] exp_out);
    int lat = exp_lat(r);
    bus.go = 1'b1; bus.left = l; bus.right = r;
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) begin
        chk({tag, "_busy_ready"}, 32'(bus.ready), 0);
        chk({tag, "_busy_done"}, 32'(bus.done), 0);
        bus.go    = k[0];
        bus.left  = W'($urandom);
        bus.right = W'($urandom);
      end else begin
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_out"}, 32'(bus.out), 32'(exp_out));
        bus.go = 1'b0;
      end
    end
    tick();
    chk({tag, "_after_done"}, 32'(bus.done), 0);
    chk({tag, "_hold"}, 32'(bus.out), 32'(exp_out));
  endtask

  initial begin
    int l1, l2;
    reset = 1'b1; bus.go = 1'b0; bus.left = '0; bus.right = '0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out", 32'(bus.out), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_ready", 32'(bus.ready), 1);
      tick();
    end

    run_op("m13x11", 8'd13, 8'd11, 8'h8F);
    run_op("mffxff", 8'hFF, 8'hFF, 8'h01);
    run_op("m80xff", 8'h80, 8'hFF, 8'h80);
    run_op("m55x00", 8'h55, 8'h00, 8'h00);
    run_op("m9x3", 8'd9, 8'd3, 8'd27);
    run_op("m1x80", 8'd1, 8'h80, 8'h80);

    // go held high: 3*5 then 7*9 back to back.
    l1 = exp_lat(8'd5);
    l2 = exp_lat(8'd9);
    bus.go = 1'b1; bus.left = 8'd3; bus.right = 8'd5;
    tick();
    bus.left = 8'd7; bus.right = 8'd9;
    for (int k = 1; k < l1; k++) begin
      chk("b2b_a_ready", 32'(bus.ready), 0);
      tick();
    end
    chk("b2b_a_done", 32'(bus.done), 1);
    chk("b2b_a_out", 32'(bus.out), 15);
    tick();
    for (int k = 1; k < l2; k++) begin
      chk("b2b_b_ready", 32'(bus.ready), 0);
      bus.left = W'($urandom); bus.right = W'($urandom);
      if (k == l2 - 1) bus.go = 1'b0;
      tick();
    end
    chk("b2b_b_done", 32'(bus.done), 1);
    chk("b2b_b_out", 32'(bus.out), 63);
    tick();
    chk("b2b_idle_done", 32'(bus.done), 0);

    // Reset in cycle 4 of an operation discards it.
    bus.go = 1'b1; bus.left = 8'd13; bus.right = 8'd11;
    tick();
    bus.go = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out", 32'(bus.out), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_ready", 32'(bus.ready), 1);
    run_op("m2x3", 8'd2, 8'd3, 8'd6);

    // Reset and go together: reset wins, nothing is started.
    bus.go = 1'b1; bus.left = 8'd4; bus.right = 8'd4; reset = 1'b1;
    tick();
    reset = 1'b0; bus.go = 1'b0;
    chk("rstgo_ready", 32'(bus.ready), 1);
    tick();
    chk("rstgo_ready2", 32'(bus.ready), 1);
    chk("rstgo_out", 32'(bus.out), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Iterative shift-add multiplier for datapaths where a combinational multiplier is too large or too slow.
- Sits directly upstream of a pipeline Register: accepts operands on a go pulse and produces the low WIDTH bits of the product several cycles later.
- Signals completion with a one-cycle done pulse; the downstream Register uses it as write_en.
- Holds the result stable until the next product completes.

Parameters:
WIDTH, 32, operand and result width in bits (WIDTH >= 1).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
go  input  1  start request; sampled only when ready=1.
left  input  WIDTH  multiplicand; captured on an accepted go.
right  input  WIDTH  multiplier; captured on an accepted go.
ready  output  1  high when a go will be accepted this cycle.
done  output  1  one-cycle pulse; out holds a new product this cycle.
out  output  WIDTH  product mod 2^WIDTH; registered, held between operations.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state = IDLE, done = 0, ready = 1, out = 0.
  - Internal accumulator, shift registers and counter are cleared.
- States: IDLE, BUSY, DONE.
  - ready = 1 in IDLE and DONE; ready = 0 in BUSY.
  - done = 1 only in DONE.
- Accepted go (state IDLE or DONE, go=1):
  - Load mcand <= left, mplier <= right, acc <= 0, count <= 0.
  - Next state = BUSY.
  - If the current state is DONE, done stays 1 for that cycle (back-to-back issue allowed).
- IDLE or DONE with go=0: next state = IDLE.
- Each BUSY cycle performs one iteration:
  - if mplier[0], acc <= acc + mcand (mod 2^WIDTH).
  - mcand <= mcand << 1 (top bit dropped).
  - mplier <= mplier >> 1.
  - count <= count + 1.
- Leaving BUSY: after the iteration where count == WIDTH-1, next state = DONE and out <= final acc (including that iteration's add).
  - out is written only on this transition.
- go is ignored while BUSY; operands change mid-operation have no effect.
- Latency (fixed): go high in cycle 0 → done high in cycle WIDTH+1. Throughput: one result per WIDTH+1 cycles.
- Arithmetic:
  - Unsigned shift-add.
  - Result is the exact low WIDTH bits of left*right; identical for two's-complement signed operands.
  - No overflow flag.
- Counter width is $clog2(WIDTH)+1 so WIDTH is reachable without wrap; the WIDTH=1 case must work.
- Reset mid-operation (any state): next cycle state=IDLE, done=0, out=0, ready=1. The in-flight product is discarded.
- Reset and go in the same cycle: reset wins; go is not accepted.

Optional Feature:
SEQ_MULT_EARLY_EXIT_EN
- Defined: BUSY also exits to DONE after any iteration whose shifted mplier (mplier>>1) is zero.
  - Latency = max(1, index of highest set bit of right + 1) + 1 cycles from go to done.
  - right=0 gives done at cycle 2.
  - Result is identical to fixed mode.
- Undefined: fixed WIDTH iterations as above; no mplier-zero comparator is synthesised.

Test Plan:
- WIDTH=8, reset for 2 cycles, then idle → out=0, done=0, ready=1 throughout.
- WIDTH=8: left=13, right=11, go in cycle 0 → ready=0 in cycles 1–8; done=1 and out=0x8F in cycle 9 only; out holds 0x8F afterwards.
- WIDTH=8: left=255, right=255 → out=0x01 at done (truncation); left=0x80, right=0xFF (signed -128*-1) → out=0x80.
- WIDTH=8: go held high continuously with operands 3*5 then 7*9 → done in cycles 9 and 18; out=15 then 63; go pulses during BUSY ignored (operands toggled mid-op do not alter the result).
- WIDTH=8: assert reset in cycle 4 of an operation → cycle 5 shows out=0, done=0, ready=1; a new go for 2*3 yields out=6 at done 9 cycles later.
- SEQ_MULT_EARLY_EXIT_EN, WIDTH=8:
  - right=0 → done cycle 2, out=0.
  - left=9, right=3 → done cycle 3, out=27.
  - right=0x80 → done cycle 9.
